// File: rtl/bmem_pkg.sv
// bmem_pkg: shared FSM state encoding and beat-size constant for burst_mem_responder.
package bmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        R_WAIT,
        R_BURST,
        W_BURST,
        W_RESP
    } state_t;

    localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/bmem_ram.sv
// bmem_ram: single-port word RAM with per-byte write enables and asynchronous read.
// Ports: clk; addr word index; we write enable; be byte enables; wdata write word;
// rdata combinational read of mem[addr].
module bmem_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: burst read/write memory responder with a fixed read latency.
// Ports: clk, rst (async, active-high); read request rvalid/raddr/rlen/rsize with beat
// outputs rready/rdata/rlast; write beats wvalid/waddr/wdata/wstrb/wlast/wlen/wsize with
// wready pulse; write response bvalid/bready.
// Macro BMEM_READ_LATENCY_EN: when defined R_WAIT lasts READ_LATENCY cycles, otherwise one.
module burst_mem_responder
    import bmem_pkg::*;
#(
    parameter int DEPTH_WIDTH  = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rvalid,
    input  logic [31:0] raddr,
    input  logic [7:0]  rlen,
    input  logic [2:0]  rsize,
    output logic        rready,
    output logic [31:0] rdata,
    output logic        rlast,
    input  logic        wvalid,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic [7:0]  wlen,
    input  logic [2:0]  wsize,
    output logic        wready,
    output logic        bvalid,
    input  logic        bready
);

`ifdef BMEM_READ_LATENCY_EN
    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);
`else
    localparam logic [3:0] LAT_LOAD = 4'd0;
    localparam int unused_lat = READ_LATENCY;
`endif

    state_t                 state, state_nx;
    logic [DEPTH_WIDTH-1:0] idx;
    logic [7:0]             cnt;
    logic [3:0]             lat;
    logic [31:0]            ram_rdata;

    // Address low bits, upper bits beyond the memory, sizes and wlast carry no
    // information: every beat is a word and the beat counter alone ends a burst.
    logic unused_bits;
    assign unused_bits = ^{raddr[31:DEPTH_WIDTH+2], raddr[1:0], waddr[31:DEPTH_WIDTH+2],
                           waddr[1:0], rsize == SIZE_WORD, wsize == SIZE_WORD, wlast};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        rready   = 1'b0;
        rlast    = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        case (state)
            IDLE:    state_nx = wvalid ? W_BURST : (rvalid ? R_WAIT : IDLE);
            R_WAIT:  state_nx = (lat == 4'd0) ? R_BURST : R_WAIT;
            R_BURST: begin
                rready   = 1'b1;
                rlast    = (cnt == 8'd0);
                state_nx = (cnt == 8'd0) ? IDLE : R_BURST;
            end
            W_BURST: begin
                wready   = wvalid;
                state_nx = (wvalid && cnt == 8'd0) ? W_RESP : W_BURST;
            end
            W_RESP: begin
                bvalid   = 1'b1;
                state_nx = bready ? IDLE : W_RESP;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            cnt <= '0;
            lat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wvalid) begin
                        idx <= waddr[DEPTH_WIDTH+1:2];
                        cnt <= wlen;
                    end else if (rvalid) begin
                        idx <= raddr[DEPTH_WIDTH+1:2];
                        cnt <= rlen;
                        lat <= LAT_LOAD;
                    end
                end
                R_WAIT: lat <= lat - 4'd1;
                R_BURST: begin
                    idx <= idx + 1'b1;
                    cnt <= cnt - 8'd1;
                end
                W_BURST: begin
                    if (wvalid) begin
                        idx <= idx + 1'b1;
                        cnt <= cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata = rready ? ram_rdata : '0;

    bmem_ram #(.AW(DEPTH_WIDTH)) u_ram (
        .clk   (clk),
        .addr  (idx),
        .we    (wready),
        .be    (wstrb),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_burst_mem_responder.sv
// tb_burst_mem_responder: directed self-checking bench for burst_mem_responder.
module tb_burst_mem_responder;
    import bmem_pkg::*;

`ifdef BMEM_READ_LATENCY_EN
    localparam int EXP_LAT = 3;
`else
    localparam int EXP_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst, rvalid, rready, rlast, wvalid, wlast, wready, bvalid, bready;
    logic [31:0] raddr, rdata, waddr, wdata;
    logic [7:0]  rlen, wlen;
    logic [2:0]  rsize, wsize;
    logic [3:0]  wstrb;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wd [8];
    logic [31:0] rd [16];
    logic        rl [16];
    int          r_beats, r_first, r_extra;
    int          w_acc, b_held, b_after, rr_during;

    always #5 clk = ~clk;

    burst_mem_responder #(.DEPTH_WIDTH(10), .READ_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .rvalid(rvalid), .raddr(raddr), .rlen(rlen), .rsize(rsize),
        .rready(rready), .rdata(rdata), .rlast(rlast),
        .wvalid(wvalid), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wlen(wlen), .wsize(wsize), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    task automatic read_collect();
        r_beats = 0;
        r_first = 0;
        r_extra = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk); #1;
            if (rready) begin
                if (r_beats == 0) r_first = i;
                if (r_beats < 16) begin
                    rd[r_beats] = rdata;
                    rl[r_beats] = rlast;
                end
                r_beats++;
                if (rlast) break;
            end
        end
        @(posedge clk); #1;
        rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (rready) r_extra++;
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz);
        @(negedge clk);
        rvalid = 1'b1;
        raddr  = a;
        rlen   = len;
        rsize  = sz;
        read_collect();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [3:0] s,
                            input int bdelay, input bit rd_en, input logic [31:0] ra,
                            input logic [7:0] rlen_i);
        w_acc     = 0;
        b_held    = 0;
        rr_during = 0;
        @(negedge clk);
        wvalid = 1'b1;
        waddr  = a;
        wlen   = len;
        wsize  = SIZE_WORD;
        wstrb  = s;
        wdata  = wd[0];
        wlast  = (len == 8'd0);
        if (rd_en) begin
            rvalid = 1'b1;
            raddr  = ra;
            rlen   = rlen_i;
            rsize  = SIZE_WORD;
        end
        for (int i = 0; i < 50 && wvalid; i++) begin
            #1;
            if (wready) w_acc++;
            if (rready) rr_during++;
            @(negedge clk);
            if (w_acc > int'(len)) wvalid = 1'b0;
            else begin
                wdata = wd[w_acc];
                wlast = (w_acc == int'(len));
            end
        end
        wvalid = 1'b0;
        for (int i = 0; i < bdelay; i++) begin
            #1;
            if (bvalid) b_held++;
            if (rready) rr_during++;
            @(negedge clk);
        end
        bready = 1'b1;
        #1;
        if (bvalid) b_held++;
        @(negedge clk);
        bready = 1'b0;
        #1;
        b_after = int'(bvalid);
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        if ({rready, rlast, rdata, wready, bvalid} !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h want 0", {rready, rlast, rdata, wready, bvalid});
        end
        n_cmp++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_preload_read();
        for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + i;
        do_write(32'h10, 8'd3, 4'hF, 0, 1'b0, 32'h0, 8'd0);
        if (w_acc !== 4) begin n_bad++; $display("FAIL preload_wready got %0d want 4", w_acc); end
        n_cmp++;
        if (b_held !== 1) begin n_bad++; $display("FAIL preload_bvalid got %0d want 1", b_held); end
        n_cmp++;
        do_read(32'h10, 8'd3, SIZE_WORD);
        if (r_beats !== 4) begin n_bad++; $display("FAIL read_beats got %0d want 4", r_beats); end
        n_cmp++;
        if (r_first !== EXP_LAT) begin
            n_bad++;
            $display("FAIL read_latency got %0d want %0d", r_first, EXP_LAT);
        end
        n_cmp++;
        for (int i = 0; i < 4; i++) begin
            if (rd[i] !== 32'hA0 + i) begin
                n_bad++;
                $display("FAIL read_data[%0d] got %h want %h", i, rd[i], 32'hA0 + i);
            end
            n_cmp++;
            if (rl[i] !== (i == 3)) begin
                n_bad++;
                $display("FAIL read_rlast[%0d] got %b want %b", i, rl[i], i == 3);
            end
            n_cmp++;
        end
        if (r_extra !== 0) begin n_bad++; $display("FAIL read_extra got %0d want 0", r_extra); end
        n_cmp++;
    endtask

    task automatic test_write();
        wd[0] = 32'h11223344;
        wd[1] = 32'h55667788;
        do_write(32'h40, 8'd1, 4'hF, 3, 1'b0, 32'h0, 8'd0);
        if (w_acc !== 2) begin n_bad++; $display("FAIL write_wready got %0d want 2", w_acc); end
        n_cmp++;
        if (b_held !== 4) begin n_bad++; $display("FAIL write_bvalid_hold got %0d want 4", b_held); end
        n_cmp++;
        if (b_after !== 0) begin n_bad++; $display("FAIL write_bvalid_drop got %0d want 0", b_after); end
        n_cmp++;
        do_read(32'h40, 8'd1, 3'b111);
        if (rd[0] !== 32'h11223344) begin n_bad++; $display("FAIL write_rb0 got %h want 11223344", rd[0]); end
        n_cmp++;
        if (rd[1] !== 32'h55667788) begin n_bad++; $display("FAIL write_rb1 got %h want 55667788", rd[1]); end
        n_cmp++;
    endtask

    task automatic test_strobe();
        wd[0] = 32'h0;
        do_write(32'h80, 8'd0, 4'hF, 0, 1'b0, 32'h0, 8'd0);
        wd[0] = 32'hFFFFFFFF;
        do_write(32'h80, 8'd0, 4'b0101, 0, 1'b0, 32'h0, 8'd0);
        do_read(32'h83, 8'd0, SIZE_WORD);
        if (rd[0] !== 32'h00FF00FF) begin n_bad++; $display("FAIL strobe got %h want 00ff00ff", rd[0]); end
        n_cmp++;
    endtask

    task automatic test_collision();
        wd[0] = 32'hCAFEF00D;
        do_write(32'h100, 8'd0, 4'hF, 1, 1'b1, 32'h40, 8'd1);
        if (rr_during !== 0) begin n_bad++; $display("FAIL coll_rready_early got %0d want 0", rr_during); end
        n_cmp++;
        if (w_acc !== 1) begin n_bad++; $display("FAIL coll_wready got %0d want 1", w_acc); end
        n_cmp++;
        read_collect();
        if (r_beats !== 2) begin n_bad++; $display("FAIL coll_beats got %0d want 2", r_beats); end
        n_cmp++;
        if (rd[0] !== 32'h11223344 || rd[1] !== 32'h55667788) begin
            n_bad++;
            $display("FAIL coll_data got %h %h want 11223344 55667788", rd[0], rd[1]);
        end
        n_cmp++;
        do_read(32'h100, 8'd0, SIZE_WORD);
        if (rd[0] !== 32'hCAFEF00D) begin n_bad++; $display("FAIL coll_wdata got %h want cafef00d", rd[0]); end
        n_cmp++;
    endtask

    task automatic test_wrap();
        wd[0] = 32'hDEADBEEF;
        wd[1] = 32'h12345678;
        do_write(32'hFFC, 8'd1, 4'hF, 0, 1'b0, 32'h0, 8'd0);
        do_read(32'h80000FFE, 8'd1, SIZE_WORD);
        if (rd[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wrap_last got %h want deadbeef", rd[0]); end
        n_cmp++;
        if (rd[1] !== 32'h12345678) begin n_bad++; $display("FAIL wrap_first got %h want 12345678", rd[1]); end
        n_cmp++;
        do_read(32'h0, 8'd0, SIZE_WORD);
        if (rd[0] !== 32'h12345678) begin n_bad++; $display("FAIL wrap_word0 got %h want 12345678", rd[0]); end
        n_cmp++;
    endtask

    task automatic test_reset_mid_burst();
        int seen = 0;
        @(negedge clk);
        rvalid = 1'b1;
        raddr  = 32'h10;
        rlen   = 8'd3;
        rsize  = SIZE_WORD;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (rready) begin seen = 1; break; end
        end
        if (seen !== 1) begin n_bad++; $display("FAIL rstmid_first_beat got %0d want 1", seen); end
        n_cmp++;
        @(negedge clk); #1;
        if ({rready, rdata} !== {1'b1, 32'hA1}) begin
            n_bad++;
            $display("FAIL rstmid_beat2 got %b %h want 1 000000a1", rready, rdata);
        end
        n_cmp++;
        rst = 1'b1;
        #1;
        if ({rready, rlast, rdata} !== 34'd0) begin
            n_bad++;
            $display("FAIL rstmid_outputs got %b %b %h want 0 0 0", rready, rlast, rdata);
        end
        n_cmp++;
        rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_read(32'h10, 8'd3, SIZE_WORD);
        if (r_first !== EXP_LAT || r_beats !== 4) begin
            n_bad++;
            $display("FAIL rstmid_restart got lat %0d beats %0d want lat %0d beats 4",
                     r_first, r_beats, EXP_LAT);
        end
        n_cmp++;
        if (rd[0] !== 32'hA0 || rd[3] !== 32'hA3) begin
            n_bad++;
            $display("FAIL rstmid_mem got %h %h want 000000a0 000000a3", rd[0], rd[3]);
        end
        n_cmp++;
    endtask

    initial begin
        rst    = 1'b1;
        rvalid = 1'b0;
        raddr  = '0;
        rlen   = '0;
        rsize  = SIZE_WORD;
        wvalid = 1'b0;
        waddr  = '0;
        wdata  = '0;
        wstrb  = '0;
        wlast  = 1'b0;
        wlen   = '0;
        wsize  = SIZE_WORD;
        bready = 1'b0;
        test_reset();
        test_preload_read();
        test_write();
        test_strobe();
        test_collision();
        test_wrap();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
